// File: rtl/cpu_uart_pkg.sv
// Shared definitions for the CPU-bus UART: register map, STATUS bit positions
// and the serial-side state encodings.
package cpu_uart_pkg;

  localparam int  ADDR_SEL_BIT    = 2;
  localparam logic REG_STATUS     = 1'b0;
  localparam logic REG_DATA       = 1'b1;

  localparam int ST_RX_AVAIL      = 0;
  localparam int ST_TX_READY      = 1;
  localparam int ST_RX_OVERRUN    = 2;
  localparam int ST_RX_FRAME_ERR  = 3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/cpu_uart_fifo.sv
// Byte FIFO, first-word-fall-through. Pointers carry one extra wrap bit so
// full and empty are distinguishable; a pop frees room for a same-cycle push.
module cpu_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cpu_uart.sv
// 8N1 UART on the CPU bus: STATUS at offset 0x0, DATA at 0x4, byte FIFOs on
// both directions and independent baud counters for RX and TX.
module cpu_uart #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_request,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  import cpu_uart_pkg::*;

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  // ---------------- bus decode ----------------
  logic        is_read, sel_data, w1c, tx_push, rx_pop;
  logic [31:0] status_word, data_word, rdata_q;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]  rx_head, tx_head;
  logic        overrun, frame_err, set_ovr, set_fe;
  logic        unused_bits;

  assign is_read  = (bus_wmask == 4'd0);
  assign sel_data = (bus_address[ADDR_SEL_BIT] == REG_DATA);
  assign w1c      = bus_request & bus_wmask[0] & ~sel_data;
  assign tx_push  = bus_request & bus_wmask[0] & sel_data;
  assign rx_pop   = bus_request & is_read & sel_data;
  assign unused_bits = ^{bus_address[31:3], bus_address[1:0], bus_wdata[31:8]};

  always_comb begin
    status_word                  = '0;
    status_word[ST_RX_AVAIL]     = ~rx_empty;
    status_word[ST_TX_READY]     = ~tx_full;
    status_word[ST_RX_OVERRUN]   = overrun;
    status_word[ST_RX_FRAME_ERR] = frame_err;
  end

  assign data_word = rx_empty ? 32'd0 : {24'd0, rx_head};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack <= 1'b0;
      rdata_q <= '0;
    end else begin
      bus_ack <= bus_request;
      rdata_q <= (bus_request && is_read) ? (sel_data ? data_word : status_word) : 32'd0;
    end
  end

  assign bus_rdata = bus_ack ? rdata_q : 32'd0;

  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= set_ovr | (overrun   & ~(w1c & bus_wdata[ST_RX_OVERRUN]));
      frame_err <= set_fe  | (frame_err & ~(w1c & bus_wdata[ST_RX_FRAME_ERR]));
    end
  end

  // ---------------- RX path ----------------
  rx_state_e   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_brk, rx_brk_n, rx_push_req;
  logic        rx_meta, rxd_s, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxd_s   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxd_s   <= rx_meta;
      rx_prev <= rxd_s;
    end
  end

  assign rx_fall = rx_prev & ~rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_brk   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_brk   <= rx_brk_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_brk_n    = rx_brk;
    rx_push_req = 1'b0;
    set_fe      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_fall) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == CW'(HALF - 1)) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == CW'(CPB - 1)) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rxd_s, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: begin
        if (rx_brk) begin
          // Framing error seen: hold off until the line idles high again.
          rx_cnt_n = '0;
          if (rxd_s) begin
            rx_brk_n   = 1'b0;
            rx_state_n = RX_IDLE;
          end
        end else if (rx_cnt == CW'(CPB - 1)) begin
          rx_cnt_n = '0;
          if (rxd_s) begin
            rx_push_req = 1'b1;
            rx_state_n  = RX_IDLE;
          end else begin
            set_fe   = 1'b1;
            rx_brk_n = 1'b1;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign set_ovr = rx_push_req & rx_full & ~rx_pop;

  cpu_uart_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push_req), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty)
  );

  // ---------------- TX path ----------------
  tx_state_e   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_pop, tx_end, txd_n;

  assign tx_end = (tx_cnt == CW'(CPB - 1));

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n   = tx_bit + 1'b1;
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
      end
      TX_STOP: if (tx_end) begin
        tx_cnt_n = '0;
        // Chain straight into the next start bit when more data is queued.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_txd <= txd_n;
    end
  end

  cpu_uart_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .wdata(bus_wdata[7:0]),
    .pop(tx_pop), .rdata(tx_head),
    .full(tx_full), .empty(tx_empty)
  );

endmodule

// File: tb/tb_cpu_uart.sv
// Bench for cpu_uart: a queue-based model of the register file and FIFOs predicts
// every bus response; a serial monitor decodes txd and checks bytes and timing.
module tb_cpu_uart;
  localparam int CPB = 100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        bus_request = 1'b0;
  logic [31:0] bus_address = '0, bus_wdata = '0;
  logic [3:0]  bus_wmask = '0;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  always #5 clk = ~clk;

  cpu_uart #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000),
             .RX_FIFO_DEPTH(16), .TX_FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_request(bus_request), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rst_events = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  int         tx_starts[$];
  bit         m_ovr = 0, m_fe = 0;
  int         tx_pushed = 0, tx_started = 0;
  logic [31:0] cur_exp = '0;

  function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                               input logic [3:0] wmask);
    logic [31:0] r;
    r = '0;
    if (wmask == 4'd0) begin
      if (addr[2]) begin
        if (rx_q.size() > 0) r = {24'd0, rx_q.pop_front()};
      end else begin
        r = {28'd0, m_fe, m_ovr, 1'((tx_pushed - tx_started) < 16), 1'(rx_q.size() > 0)};
      end
    end else if (wmask[0]) begin
      if (addr[2]) begin
        if ((tx_pushed - tx_started) < 16) begin
          tx_exp.push_back(wdata[7:0]);
          tx_pushed++;
        end
      end else begin
        if (wdata[2]) m_ovr = 0;
        if (wdata[3]) m_fe = 0;
      end
    end
    return r;
  endfunction

  // Expected bus response: ack one cycle after request, data only with ack.
  logic        e_ack;
  logic [31:0] e_rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ack <= 1'b0;
      e_rd  <= '0;
    end else begin
      e_ack <= bus_request;
      e_rd  <= bus_request ? cur_exp : 32'd0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_events++;

  always @(negedge clk) begin
    chk("bus_ack", {31'd0, bus_ack}, {31'd0, e_ack});
    chk("bus_rdata", bus_rdata, e_rd);
    if (!rst_n) chk("txd_in_reset", {31'd0, uart_txd}, 32'd1);
  end

  // ---------------- TX serial monitor ----------------
  initial begin : tx_mon
    int          r0, st;
    logic [7:0]  b;
    logic        s_start, s_stop;
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd === 1'b0) begin
        r0 = rst_events;
        st = cyc;
        tx_started++;
        repeat (CPB/2) @(negedge clk);
        s_start = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        s_stop = uart_txd;
        if (rst_events == r0) begin
          tx_starts.push_back(st);
          chk("tx_start_bit", {31'd0, s_start}, 32'd0);
          chk("tx_stop_bit", {31'd0, s_stop}, 32'd1);
          if (tx_exp.size() == 0) chk("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
          else chk("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask, output logic [31:0] rd);
    cur_exp     = model_access(addr, wdata, wmask);
    bus_address = addr;
    bus_wdata   = wdata;
    bus_wmask   = wmask;
    bus_request = 1'b1;
    @(posedge clk);
    #1 bus_request = 1'b0;
    @(negedge clk);
    rd = bus_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      uart_rxd = 1'b1;
      repeat (20) @(negedge clk);
      m_fe = 1;
    end else if (rx_q.size() < 16) rx_q.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic wait_tx_drain(input int limit);
    int t;
    t = 0;
    while (tx_exp.size() > 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("tx_drain_timeout", tx_exp.size(), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] rd;
    int n0, n;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    bus(32'h0, 0, 4'h0, rd); chk("reset_status", rd, 32'h2);

    // Single received byte
    send_rx(8'hA5, 1);
    bus(32'h0, 0, 4'h0, rd); chk("status_rx_avail", rd, 32'h3);
    bus(32'h4, 0, 4'h0, rd); chk("data_a5", rd, 32'hA5);
    bus(32'h0, 0, 4'h0, rd); chk("status_after_pop", rd, 32'h2);
    bus(32'h4, 0, 4'h0, rd); chk("data_empty", rd, 32'h0);

    // Back-to-back TX bytes
    n0 = tx_starts.size();
    bus(32'h4, 32'h55, 4'h1, rd);
    bus(32'h4, 32'h0F, 4'h1, rd);
    wait_tx_drain(3000);
    chk("tx_frames", tx_starts.size() - n0, 32'd2);
    if (tx_starts.size() >= n0 + 2) chk("tx_no_gap", tx_starts[n0+1] - tx_starts[n0], 32'd1000);

    // RX overrun: 17 bytes with no reads
    for (int k = 0; k < 17; k++) send_rx(8'(k * 37 + 11), 1);
    bus(32'h0, 0, 4'h0, rd); chk("status_overrun", rd, 32'h7);
    bus(32'h0, 32'h4, 4'h1, rd);
    bus(32'h0, 0, 4'h0, rd); chk("status_ovr_cleared", rd, 32'h3);
    for (int k = 0; k < 16; k++) begin
      bus(32'h4, 0, 4'h0, rd); chk("ovr_data", rd, {24'd0, 8'(k * 37 + 11)});
    end
    bus(32'h0, 0, 4'h0, rd); chk("status_drained", rd, 32'h2);

    // Framing error, then a short glitch
    send_rx(8'h33, 0);
    bus(32'h0, 0, 4'h0, rd); chk("status_frame_err", rd, 32'hA);
    bus(32'h4, 0, 4'h0, rd); chk("frame_err_no_push", rd, 32'h0);
    bus(32'h0, 32'h8, 4'h1, rd);
    uart_rxd = 1'b0;
    repeat (30) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    bus(32'h0, 0, 4'h0, rd); chk("status_after_glitch", rd, 32'h2);

    // TX FIFO full: 18 writes, one goes straight to the shifter, the last is dropped
    n0 = tx_starts.size();
    for (int k = 0; k < 18; k++) bus(32'h4, 32'h40 + k, 4'h1, rd);
    bus(32'h0, 0, 4'h0, rd); chk("status_tx_full", rd, 32'h0);
    wait_tx_drain(20000);
    repeat (CPB) @(negedge clk);
    chk("tx_full_frames", tx_starts.size() - n0, 32'd17);
    bus(32'h0, 0, 4'h0, rd); chk("status_tx_drained", rd, 32'h2);

    // Randomized traffic against the model
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) send_rx(8'($urandom), 1);
      if ($urandom_range(0, 1) == 1) bus(32'h4, $urandom, 4'h1, rd);
      bus(32'h0, 0, 4'h0, rd);
      for (int k = 0; k <= n; k++) begin
        bus(32'h4, $urandom & 32'hFFFF_FFF4 | 32'h4, 4'h0, rd);
        if ($urandom_range(0, 2) == 0) bus(32'h0, $urandom, 4'h0, rd);
      end
      bus(32'h0, $urandom, 4'($urandom_range(0, 15)), rd);
    end
    wait_tx_drain(4000);

    // Reset mid RX byte and mid TX byte
    bus(32'h4, 32'hC3, 4'h1, rd);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (250) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("txd_async_reset", {31'd0, uart_txd}, 32'd1);
    rx_q.delete();
    tx_exp.delete();
    m_ovr = 0; m_fe = 0;
    tx_pushed = 0; tx_started = 0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    bus(32'h0, 0, 4'h0, rd); chk("status_post_reset", rd, 32'h2);
    bus(32'h4, 0, 4'h0, rd); chk("data_post_reset", rd, 32'h0);
    chk("no_tx_post_reset", tx_started, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
